dual_buf_ctrl: RTL and testbench

DUAL_BUF_CTRL -- requirements
Module: dual_buf_ctrl

---
 rtl/dual_buf_pkg.sv | 11 +
 rtl/dual_buf_phase_gen.sv | 44 ++++
 rtl/dual_buf_ctrl.sv | 100 ++++++++++
 tb/tb_dual_buf_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dual_buf_pkg.sv
// Shared definitions for the dual-buffer scheduling controller:
// FSM state encoding and packet width.
package dual_buf_pkg;
    localparam int PKT_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/dual_buf_phase_gen.sv
// Phase counter and the two shift-enable strobes. The strobes are registered
// and computed from next-state/next-count, so they line up with the live count.
module dual_buf_phase_gen #(
    parameter int DIV    = 8,
    parameter int OFFSET = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run_now,
    input  logic run_next,
    output logic sh_en1,
    output logic sh_en2
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sh_en1_q, sh_en1_d;
    logic          sh_en2_q, sh_en2_d;

    always_comb begin
        cnt_d = '0;
        // Count only while staying in RUN; the first RUN cycle sees count 0.
        if (run_now && run_next) begin
            cnt_d = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + 1'b1;
        end
        sh_en1_d = run_next && (cnt_d == '0);
        sh_en2_d = run_next && (cnt_d == CW'(OFFSET));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            sh_en1_q <= 1'b0;
            sh_en2_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sh_en1_q <= sh_en1_d;
            sh_en2_q <= sh_en2_d;
        end
    end

    assign sh_en1 = sh_en1_q;
    assign sh_en2 = sh_en2_q;
endmodule

// File: rtl/dual_buf_ctrl.sv
// Dual-buffer controller: IDLE/RUN/DRAIN scheduler, packet capture into a
// one-deep valid/ready holding register, and accepted/dropped packet counters.
module dual_buf_ctrl
    import dual_buf_pkg::*;
#(
    parameter int DIV    = 8,
    parameter int OFFSET = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pkt_rec,
    input  logic [PKT_W-1:0] din,
    output logic             sh_en1,
    output logic             sh_en2,
    output logic             pkt_valid,
    output logic [PKT_W-1:0] pkt_data,
    input  logic             pkt_ready,
    output logic             busy,
    output logic [15:0]      pkt_cnt,
    output logic [7:0]       drop_cnt,
    output logic [1:0]       state_dbg
);
    // Handshake: a held packet transfers on any cycle where pkt_valid and
    // pkt_ready are both high at the clock edge; pkt_data is frozen otherwise.

    state_t           state_q, state_d;
    logic             rec_q;
    logic             valid_q, valid_d;
    logic [PKT_W-1:0] data_q, data_d;
    logic [15:0]      pkt_cnt_q, pkt_cnt_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic             capture, accept;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start && !stop)         state_d = ST_RUN;
            ST_RUN:   if (stop)                   state_d = ST_DRAIN;
            ST_DRAIN: if (!valid_q || pkt_ready)  state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase

        capture = pkt_rec && !rec_q && (state_q == ST_RUN);
        accept  = capture && (!valid_q || pkt_ready);

        valid_d    = valid_q;
        data_d     = data_q;
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (accept) begin
            valid_d   = 1'b1;
            data_d    = din;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end else if (valid_q && pkt_ready) begin
            valid_d = 1'b0;
        end
        if (capture && !accept && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rec_q      <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rec_q      <= pkt_rec;
            valid_q    <= valid_d;
            data_q     <= data_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    dual_buf_phase_gen #(
        .DIV    (DIV),
        .OFFSET (OFFSET)
    ) u_phase_gen (
        .clk      (clk),
        .rst      (rst),
        .run_now  (state_q == ST_RUN),
        .run_next (state_d == ST_RUN),
        .sh_en1   (sh_en1),
        .sh_en2   (sh_en2)
    );

    assign pkt_valid = valid_q;
    assign pkt_data  = data_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;
endmodule

// File: tb/tb_dual_buf_ctrl.sv
// Directed bench for dual_buf_ctrl: strobe timing, capture, overflow,
// simultaneous capture/handshake, drain and asynchronous reset.
module tb_dual_buf_ctrl;
    localparam int DIV    = 8;
    localparam int OFFSET = 4;

    // clock / reset
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0, pkt_rec = 1'b0, pkt_ready = 1'b0;
    logic [63:0] din = '0;
    logic        sh_en1, sh_en2, pkt_valid, busy;
    logic [63:0] pkt_data;
    logic [15:0] pkt_cnt;
    logic [7:0]  drop_cnt;
    logic [1:0]  state_dbg;

    always #5 clk = ~clk;

    dual_buf_ctrl #(.DIV(DIV), .OFFSET(OFFSET)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .pkt_rec   (pkt_rec),
        .din       (din),
        .sh_en1    (sh_en1),
        .sh_en2    (sh_en2),
        .pkt_valid (pkt_valid),
        .pkt_data  (pkt_data),
        .pkt_ready (pkt_ready),
        .busy      (busy),
        .pkt_cnt   (pkt_cnt),
        .drop_cnt  (drop_cnt),
        .state_dbg (state_dbg)
    );

    // scoreboard
    int          tests = 0;
    int          fails = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor samples just before the posedge that consumes the handshake.
    always @(negedge clk) begin
        #3;
        if (!rst && pkt_valid && pkt_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL handshake_unexpected: got %0h expected none", pkt_data);
            end else begin
                check("handshake_data", pkt_data, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_rec(input logic [63:0] d);
        din     = d;
        pkt_rec = 1'b1;
        step();
        pkt_rec = 1'b0;
        step();
    endtask

    initial begin
        repeat (2) step();
        check("rst_sh_en1", 64'(sh_en1), 64'd0);
        check("rst_sh_en2", 64'(sh_en2), 64'd0);
        check("rst_valid", 64'(pkt_valid), 64'd0);
        check("rst_data", pkt_data, 64'd0);
        check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        step();

        // strobe timing over three periods
        start = 1'b1;
        step();
        start = 1'b0;
        check("run_busy", 64'(busy), 64'd1);
        for (int k = 0; k < 24; k++) begin
            check($sformatf("sh_en1_c%0d", k), 64'(sh_en1), 64'((k % DIV) == 0));
            check($sformatf("sh_en2_c%0d", k), 64'(sh_en2), 64'((k % DIV) == OFFSET));
            step();
        end

        // single packet, held level gives one event
        din     = 64'hDEADBEEF_CAFEF00D;
        pkt_rec = 1'b1;
        exp_q.push_back(64'hDEADBEEF_CAFEF00D);
        step();
        check("single_valid", 64'(pkt_valid), 64'd1);
        check("single_data", pkt_data, 64'hDEADBEEF_CAFEF00D);
        check("single_cnt", 64'(pkt_cnt), 64'd1);
        step();
        check("level_cnt", 64'(pkt_cnt), 64'd1);
        check("level_drop", 64'(drop_cnt), 64'd0);
        pkt_rec = 1'b0;
        repeat (2) step();
        check("hold_valid", 64'(pkt_valid), 64'd1);
        check("hold_data", pkt_data, 64'hDEADBEEF_CAFEF00D);
        pkt_ready = 1'b1;
        step();
        pkt_ready = 1'b0;
        check("single_cleared", 64'(pkt_valid), 64'd0);

        // overflow: one drop
        exp_q.push_back(64'hAAAA_5555_AAAA_5555);
        pulse_rec(64'hAAAA_5555_AAAA_5555);
        check("ovf_first_cnt", 64'(pkt_cnt), 64'd2);
        pulse_rec(64'h1);
        check("ovf_drop1", 64'(drop_cnt), 64'd1);
        check("ovf_data_kept", pkt_data, 64'hAAAA_5555_AAAA_5555);
        check("ovf_cnt_kept", 64'(pkt_cnt), 64'd2);

        // simultaneous capture and handshake
        exp_q.push_back(64'h2);
        din       = 64'h2;
        pkt_rec   = 1'b1;
        pkt_ready = 1'b1;
        step();
        pkt_rec   = 1'b0;
        pkt_ready = 1'b0;
        check("simul_valid", 64'(pkt_valid), 64'd1);
        check("simul_data", pkt_data, 64'h2);
        check("simul_drop", 64'(drop_cnt), 64'd1);
        check("simul_cnt", 64'(pkt_cnt), 64'd3);
        step();

        // overflow to saturation (300 dropped edges in total)
        repeat (299) pulse_rec(64'h1);
        check("sat_drop", 64'(drop_cnt), 64'd255);
        check("sat_data", pkt_data, 64'h2);
        check("sat_cnt", 64'(pkt_cnt), 64'd3);

        // stop while holding a packet
        stop = 1'b1;
        step();
        check("drain_busy", 64'(busy), 64'd1);
        check("drain_state", 64'(state_dbg), 64'd2);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("drain_sh_en1_c%0d", k), 64'(sh_en1), 64'd0);
            check($sformatf("drain_sh_en2_c%0d", k), 64'(sh_en2), 64'd0);
            step();
        end
        pulse_rec(64'hFFFF_0000_FFFF_0000);
        check("drain_no_capture_cnt", 64'(pkt_cnt), 64'd3);
        check("drain_no_capture_data", pkt_data, 64'h2);
        check("drain_still_busy", 64'(busy), 64'd1);
        stop      = 1'b0;
        pkt_ready = 1'b1;
        step();
        pkt_ready = 1'b0;
        check("drain_exit_busy", 64'(busy), 64'd0);
        check("drain_exit_valid", 64'(pkt_valid), 64'd0);

        // asynchronous reset mid-RUN with a held packet
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        din     = 64'h5;
        pkt_rec = 1'b1;
        step();
        pkt_rec = 1'b0;
        check("pre_rst_valid", 64'(pkt_valid), 64'd1);
        check("pre_rst_cnt", 64'(pkt_cnt), 64'd4);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 64'(pkt_valid), 64'd0);
        check("arst_data", pkt_data, 64'd0);
        check("arst_cnt", 64'(pkt_cnt), 64'd0);
        check("arst_drop", 64'(drop_cnt), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_sh_en", 64'({sh_en1, sh_en2}), 64'd0);
        #1 rst = 1'b0;
        start = 1'b1;
        stop  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("post_rst_idle_c%0d", k), 64'(busy), 64'd0);
            check($sformatf("post_rst_sh_en1_c%0d", k), 64'(sh_en1), 64'd0);
        end
        start = 1'b0;
        stop  = 1'b0;
        step();
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
